// File: rtl/spi_reset_supervisor_if.sv
// Bus bundle for spi_reset_supervisor: reset requests and SPI lines in, supervised
// system reset, SPI realign pulse and status out.
interface spi_reset_supervisor_if #(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0] rst_req;
    logic             spi_clk;
    logic             spi_cs;
    logic             reset;
    logic             spi_reset;
    logic             bit_cnt_zero;
    logic [7:0]       abort_cnt;
    logic [7:0]       dbg;

    modport master (
        output rst_req, spi_clk, spi_cs,
        input  reset, spi_reset, bit_cnt_zero, abort_cnt, dbg
    );

    modport slave (
        input  rst_req, spi_clk, spi_cs,
        output reset, spi_reset, bit_cnt_zero, abort_cnt, dbg
    );
endinterface

// File: rtl/spi_reset_supervisor.sv
// Merges async reset requests into a stretched synchronous reset and pulses spi_reset
// when an SPI frame is aborted. Define SPI_TIMEOUT_EN to also abort on a stalled sclk.
module spi_reset_supervisor #(
    parameter int N_SRC       = 2,
    parameter int STRETCH     = 32,
    parameter int FRAME_LEN   = 168,
    parameter int SPI_RST_CYC = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_reset_supervisor_if.slave bus
);
    localparam int SW = $clog2(STRETCH + 1);
    localparam int BW = $clog2(FRAME_LEN);
    localparam int PW = (SPI_RST_CYC > 1) ? $clog2(SPI_RST_CYC) : 1;
    localparam logic [SW-1:0] STRETCH_END = SW'(STRETCH);
    localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(SPI_RST_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT, WAIT_CS} state_t;

    logic [N_SRC-1:0] req_s1, req_s2;
    logic [SW-1:0]    stretch_cnt, stretch_nxt;
    logic             reset_r;
    logic             sclk_s1, sclk_s2, sclk_s3;
    logic             cs_s1, cs_s2, cs_s3;
    logic             sclk_rise, cs_fall, cs_rise, count_en;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [PW-1:0]    pulse_cnt;
    logic [7:0]       abort_cnt;
    logic             spi_reset_r, spi_reset_d, abort_entry;
    logic             timeout_hit;
    state_t           state, state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_s1 <= '0;
            req_s2 <= '0;
        end else begin
            req_s1 <= bus.rst_req;
            req_s2 <= req_s1;
        end
    end

    // Any synced request restarts the stretch; the counter parks at STRETCH once done.
    always_comb begin
        stretch_nxt = stretch_cnt;
        if (|req_s2)
            stretch_nxt = '0;
        else if (stretch_cnt < STRETCH_END)
            stretch_nxt = stretch_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stretch_cnt <= '0;
            reset_r     <= 1'b1;
        end else begin
            stretch_cnt <= stretch_nxt;
            reset_r     <= (stretch_nxt < STRETCH_END);
        end
    end

    // Chip-select flops preset high so an idle bus never looks like a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
        end else begin
            sclk_s1 <= bus.spi_clk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= bus.spi_cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
        end
    end

    assign sclk_rise = sclk_s2 && !sclk_s3;
    assign cs_fall   = !cs_s2 && cs_s3;
    assign cs_rise   = cs_s2 && !cs_s3;

    // An edge coinciding with CS release still counts (cs was low last cycle).
    assign count_en = sclk_rise && !reset_r && (!cs_s2 || !cs_s3) &&
                      ((state == ACTIVE) || ((state == IDLE) && cs_fall));

    always_comb begin
        bit_nxt = bit_cnt;
        if (count_en)
            bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end

`ifdef SPI_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_cnt;
    logic          idle_run;

    assign idle_run    = (state == ACTIVE) && (bit_cnt != '0) && !count_en && !reset_r;
    assign timeout_hit = idle_run && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (idle_run)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    // TIMEOUT is only meaningful when the idle counter is built.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (reset_r) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = ACTIVE;
                ACTIVE: begin
                    if (cs_rise)
                        state_nxt = (bit_nxt == '0) ? IDLE : ABORT;
                    else if (timeout_hit)
                        state_nxt = ABORT;
                end
                ABORT:   if (pulse_cnt == PULSE_LAST) state_nxt = cs_s2 ? IDLE : WAIT_CS;
                WAIT_CS: if (cs_s2) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        spi_reset_d = (state_nxt == ABORT);
        abort_entry = (state_nxt == ABORT) && (state != ABORT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            pulse_cnt   <= '0;
            abort_cnt   <= '0;
            spi_reset_r <= 1'b0;
        end else begin
            spi_reset_r <= spi_reset_d;
            if (reset_r || abort_entry)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_nxt;
            if (abort_entry)
                pulse_cnt <= '0;
            else if (state == ABORT)
                pulse_cnt <= pulse_cnt + 1'b1;
            if (abort_entry && (abort_cnt != 8'hFF))
                abort_cnt <= abort_cnt + 8'd1;
        end
    end

    assign bus.reset        = reset_r;
    assign bus.spi_reset    = spi_reset_r;
    assign bus.bit_cnt_zero = (bit_cnt == '0);
    assign bus.abort_cnt    = abort_cnt;
    assign bus.dbg          = {3'b000, timeout_hit, (state == ABORT), cs_s2, (bit_cnt == '0), reset_r};
endmodule
